memshare_alloc_sched: RTL and testbench
=======================================

Name: memshare_alloc_sched

Overview:
Allocation scheduler for the shared-memory (memShare) access path. It accepts one request bitmask per memShare pipeline cycle. It splits the mask into one or two allocation sequences of at most PORT_NUM requesters each and assigns every granted requester a shared-port index. It drives isGtr_o back to the memShare progress monitor, which returns the pipeline-cycle-begin flag that gates acceptance.

Parameters:
RQST_NUM, 12, number of requesters (bits in request mask)
PORT_NUM, 4, number of shared memory ports per allocation sequence
PORT_IDX_W, $clog2(PORT_NUM), localparam, width of one port index
CNT_W, $clog2(RQST_NUM+1), localparam, popcount width

Ports:
sys_clk  in  1  clock
rstn  in  1  synchronous active-low reset
pipe_begin_i  in  1  pipeline-cycle-begin flag from the memShare monitor
rqst_valid_i  in  1  request mask valid
rqst_mask_i  in  RQST_NUM  requester bitmask
rqst_ready_o  out  1  request accepted this cycle when high with rqst_valid_i
alloc_valid_o  out  1  allocation batch valid
alloc_ready_i  in  1  downstream accepts batch
alloc_mask_o  out  RQST_NUM  requesters granted in this batch
alloc_port_o  out  RQST_NUM*PORT_IDX_W  per-requester port index; 0 for non-granted
alloc_seq_o  out  1  0 = first sequence, 1 = second sequence
alloc_last_o  out  1  final batch of the current request
isGtr_o  out  1  one-cycle pulse: current request needs two sequences
busy_o  out  1  FSM not in IDLE
err_ovf_o  out  1  sticky: request exceeded 2*PORT_NUM set bits

Behaviour:
- Reset (rstn=0 at a sys_clk edge): FSM goes to IDLE. All outputs 0, err_ovf_o included. Latched mask is cleared. Reset mid-operation discards the pending batch and takes effect in one cycle.
- rqst_ready_o = (state==IDLE) & pipe_begin_i. This is combinational and has no dependence on rqst_valid_i.
- Accept at cycle T (valid & ready):
  - Latch the mask and compute popcount P.
  - Register isGtr_o = (P > PORT_NUM) and present it in T+1 only, as a one-cycle pulse.
- FSM states: IDLE, SEQ0, SEQ1.
  - IDLE -> SEQ0 on accept with P>0.
  - IDLE stays in IDLE on accept with P==0. The mask is consumed, no alloc_valid_o is produced, and isGtr_o=0.
  - SEQ0 -> IDLE on alloc_ready_i when P<=PORT_NUM.
  - SEQ0 -> SEQ1 on alloc_ready_i when P>PORT_NUM.
  - SEQ1 -> IDLE on alloc_ready_i.
- alloc_valid_o is high in SEQ0 and SEQ1. First batch appears at T+1.
- Batch contents:
  - SEQ0 grants the lowest min(P, PORT_NUM) set bits. The k-th lowest granted bit (k from 0) gets port k.
  - SEQ1 grants set bits of rank PORT_NUM up to min(P, 2*PORT_NUM)-1. The bit of rank PORT_NUM+k gets port k.
- alloc_seq_o = (state==SEQ1). alloc_last_o is high on the final batch of the request.
- Handshake: while alloc_valid_o & ~alloc_ready_i, all alloc_* outputs hold stable. The transfer completes on the cycle where both are high.
- Overflow: if P > 2*PORT_NUM, err_ovf_o sets at T+1 and stays set until reset. Bits of rank >= 2*PORT_NUM are dropped, and two sequences are issued normally.
- No new acceptance outside IDLE. Requests that miss pipe_begin_i wait; the block does not buffer them internally.
- Batch/port computation is registered from the latched mask. Outputs are glitch-free registers or decodes of state.

Test Plan:
1. Two-bit request: mask 12'h005 accepted at T -> T+1: alloc_valid_o=1, alloc_mask_o=12'h005, port[bit0]=0, port[bit2]=1, alloc_seq_o=0, alloc_last_o=1, isGtr_o=0; T+2: busy_o=0.
2. Two-sequence split: mask 12'h07F (P=7) -> T+1: isGtr_o=1, mask 12'h00F, ports 0..3, last=0; T+2: alloc_seq_o=1, mask 12'h070, port[4]=0, port[5]=1, port[6]=2, last=1; isGtr_o=0.
3. Acceptance gating: rqst_valid_i=1 with pipe_begin_i=0 for 3 cycles -> rqst_ready_o=0, no alloc. On pipe_begin_i=1 -> accepted, first batch next cycle.
4. Backpressure: P=7, alloc_ready_i=0 for 3 cycles in SEQ0 -> mask 12'h00F and ports held constant. SEQ1 follows the cycle after alloc_ready_i rises. No acceptance while busy_o=1.
5. Overflow and empty: mask 12'h3FF -> err_ovf_o=1 from T+1; batches 12'h00F then 12'h0F0; err_ovf_o stays 1. A later mask 12'h000 -> accepted, no alloc_valid_o, isGtr_o=0, err_ovf_o still 1.
6. Reset mid-SEQ1 (P=7, rstn=0 one cycle while SEQ1 is stalled) -> next cycle all outputs 0, busy_o=0, err_ovf_o=0. A fresh 12'h001 is then scheduled normally.

Source files
------------

// File: rtl/memshare_alloc_sched.sv
// rtl/memshare_alloc_sched.sv - memShare allocation scheduler: splits a request mask into port-indexed batches
//
// Purpose:
//   Accepts one requester bitmask per memShare pipeline cycle and issues at most
//   two allocation batches. Each batch grants up to PORT_NUM requesters. Every
//   granted requester gets the shared-port index equal to its rank within the batch.
//
// Ports:
//   sys_clk, rstn     clock and synchronous active-low reset
//   pipe_begin_i      pipeline-cycle-begin flag; gates acceptance
//   rqst_valid_i      request mask valid
//   rqst_mask_i       requester bitmask
//   rqst_ready_o      request accepted when high together with rqst_valid_i
//   alloc_valid_o     batch valid
//   alloc_ready_i     downstream accepts batch
//   alloc_mask_o      requesters granted in this batch
//   alloc_port_o      per-requester port index (PORT_IDX_W bits each), 0 if not granted
//   alloc_seq_o       0 = first sequence, 1 = second sequence
//   alloc_last_o      final batch of the current request
//   isGtr_o           one-cycle pulse: accepted request needs two sequences
//   busy_o            scheduler not idle
//   err_ovf_o         sticky: a request had more than 2*PORT_NUM bits set

module memshare_alloc_sched #(
  parameter  int RQST_NUM   = 12,
  parameter  int PORT_NUM   = 4,
  localparam int PORT_IDX_W = $clog2(PORT_NUM),
  localparam int CNT_W      = $clog2(RQST_NUM + 1)
) (
  input  logic                           sys_clk,
  input  logic                           rstn,
  input  logic                           pipe_begin_i,
  input  logic                           rqst_valid_i,
  input  logic [RQST_NUM-1:0]            rqst_mask_i,
  output logic                           rqst_ready_o,
  output logic                           alloc_valid_o,
  input  logic                           alloc_ready_i,
  output logic [RQST_NUM-1:0]            alloc_mask_o,
  output logic [RQST_NUM*PORT_IDX_W-1:0] alloc_port_o,
  output logic                           alloc_seq_o,
  output logic                           alloc_last_o,
  output logic                           isGtr_o,
  output logic                           busy_o,
  output logic                           err_ovf_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEQ0 = 2'd1,
    S_SEQ1 = 2'd2
  } state_t;

  state_t                        r_state;
  state_t                        w_state_nxt;

  logic [RQST_NUM-1:0]           r_mask;
  logic                          r_gtr;
  logic                          r_isgtr;
  logic                          r_err;
  logic [RQST_NUM-1:0]           r_alloc_mask;
  logic [RQST_NUM*PORT_IDX_W-1:0] r_alloc_port;
  logic                          r_last;

  logic                          w_accept;
  logic [RQST_NUM-1:0]           w_src;
  logic [CNT_W-1:0]              w_pop;
  logic                          w_gtr;
  logic                          w_ovf;
  logic [RQST_NUM-1:0]           w_b0_mask;
  logic [RQST_NUM-1:0]           w_b1_mask;
  logic [RQST_NUM*PORT_IDX_W-1:0] w_b0_port;
  logic [RQST_NUM*PORT_IDX_W-1:0] w_b1_port;

  assign w_accept = rqst_valid_i & rqst_ready_o;

  // In IDLE the batches are built from the incoming mask so the first batch is
  // registered at acceptance; afterwards they are rebuilt from the latched copy.
  assign w_src = (r_state == S_IDLE) ? rqst_mask_i : r_mask;

  // Rank every set bit from the LSB upward. Ranks 0..PORT_NUM-1 form the first
  // batch, ranks PORT_NUM..2*PORT_NUM-1 the second; higher ranks are dropped.
  always_comb begin
    int cnt;
    cnt       = 0;
    w_b0_mask = '0;
    w_b1_mask = '0;
    w_b0_port = '0;
    w_b1_port = '0;
    for (int i = 0; i < RQST_NUM; i++) begin
      if (w_src[i]) begin
        if (cnt < PORT_NUM) begin
          w_b0_mask[i] = 1'b1;
          w_b0_port[i*PORT_IDX_W +: PORT_IDX_W] = PORT_IDX_W'(cnt);
        end else if (cnt < 2 * PORT_NUM) begin
          w_b1_mask[i] = 1'b1;
          w_b1_port[i*PORT_IDX_W +: PORT_IDX_W] = PORT_IDX_W'(cnt - PORT_NUM);
        end
        cnt = cnt + 1;
      end
    end
    w_pop = CNT_W'(cnt);
  end

  assign w_gtr = (int'(w_pop) > PORT_NUM);
  assign w_ovf = (int'(w_pop) > 2 * PORT_NUM);

  // State register
  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        // An empty mask is consumed without producing a batch.
        if (w_accept && (w_pop != '0)) begin
          w_state_nxt = S_SEQ0;
        end
      end
      S_SEQ0: begin
        if (alloc_ready_i) begin
          w_state_nxt = r_gtr ? S_SEQ1 : S_IDLE;
        end
      end
      S_SEQ1: begin
        if (alloc_ready_i) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    rqst_ready_o  = 1'b0;
    alloc_valid_o = 1'b0;
    alloc_seq_o   = 1'b0;
    busy_o        = 1'b0;
    case (r_state)
      S_IDLE: rqst_ready_o = pipe_begin_i;
      S_SEQ0: begin
        alloc_valid_o = 1'b1;
        busy_o        = 1'b1;
      end
      S_SEQ1: begin
        alloc_valid_o = 1'b1;
        alloc_seq_o   = 1'b1;
        busy_o        = 1'b1;
      end
      default: ;
    endcase
  end

  // Batch registers. They only change on acceptance or on a completed
  // transfer, so they hold stable while the downstream stalls.
  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      r_mask       <= '0;
      r_gtr        <= 1'b0;
      r_isgtr      <= 1'b0;
      r_err        <= 1'b0;
      r_alloc_mask <= '0;
      r_alloc_port <= '0;
      r_last       <= 1'b0;
    end else begin
      r_isgtr <= 1'b0;
      if (w_accept) begin
        r_mask       <= rqst_mask_i;
        r_gtr        <= w_gtr;
        r_isgtr      <= w_gtr;
        r_alloc_mask <= w_b0_mask;
        r_alloc_port <= w_b0_port;
        r_last       <= (w_pop != '0) && !w_gtr;
        if (w_ovf) begin
          r_err <= 1'b1;
        end
      end else if (alloc_valid_o && alloc_ready_i) begin
        if ((r_state == S_SEQ0) && r_gtr) begin
          r_alloc_mask <= w_b1_mask;
          r_alloc_port <= w_b1_port;
          r_last       <= 1'b1;
        end else begin
          r_alloc_mask <= '0;
          r_alloc_port <= '0;
          r_last       <= 1'b0;
        end
      end
    end
  end

  assign alloc_mask_o = r_alloc_mask;
  assign alloc_port_o = r_alloc_port;
  assign alloc_last_o = r_last;
  assign isGtr_o      = r_isgtr;
  assign err_ovf_o    = r_err;

endmodule

// File: tb/tb_memshare_alloc_sched.sv
// tb/tb_memshare_alloc_sched.sv - scoreboard testbench for memshare_alloc_sched

module tb_memshare_alloc_sched;

  localparam int RN = 12;
  localparam int PN = 4;
  localparam int IW = 2;

  logic          sys_clk = 1'b0;
  logic          rstn = 1'b0;
  logic          pipe_begin_i = 1'b0;
  logic          rqst_valid_i = 1'b0;
  logic [RN-1:0] rqst_mask_i = '0;
  logic          rqst_ready_o;
  logic          alloc_valid_o;
  logic          alloc_ready_i = 1'b1;
  logic [RN-1:0] alloc_mask_o;
  logic [RN*IW-1:0] alloc_port_o;
  logic          alloc_seq_o;
  logic          alloc_last_o;
  logic          isGtr_o;
  logic          busy_o;
  logic          err_ovf_o;

  memshare_alloc_sched #(.RQST_NUM(RN), .PORT_NUM(PN)) dut (
    .sys_clk      (sys_clk),
    .rstn         (rstn),
    .pipe_begin_i (pipe_begin_i),
    .rqst_valid_i (rqst_valid_i),
    .rqst_mask_i  (rqst_mask_i),
    .rqst_ready_o (rqst_ready_o),
    .alloc_valid_o(alloc_valid_o),
    .alloc_ready_i(alloc_ready_i),
    .alloc_mask_o (alloc_mask_o),
    .alloc_port_o (alloc_port_o),
    .alloc_seq_o  (alloc_seq_o),
    .alloc_last_o (alloc_last_o),
    .isGtr_o      (isGtr_o),
    .busy_o       (busy_o),
    .err_ovf_o    (err_ovf_o)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [RN-1:0]    mask;
    logic [RN*IW-1:0] port;
    logic             seq;
    logic             last;
  } batch_t;

  batch_t q[$];
  logic   exp_gtr = 1'b0;
  logic   m_err = 1'b0;
  logic   m_empty;
  int     n_tests = 0;
  int     n_fail = 0;

  logic   rdy_rand = 1'b0;
  logic   rdy_force = 1'b1;
  logic   pb_rand = 1'b0;
  logic   pb_force = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: list the set-bit positions, take the first PORT_NUM as
  // sequence 0 and the next PORT_NUM as sequence 1.
  task automatic model_accept(input logic [RN-1:0] m);
    int     idx[$];
    batch_t b;
    for (int i = 0; i < RN; i++) if (m[i]) idx.push_back(i);
    exp_gtr = (idx.size() > PN);
    if (idx.size() > 2 * PN) m_err = 1'b1;
    if (idx.size() == 0) return;
    b.mask = '0; b.port = '0; b.seq = 1'b0; b.last = (idx.size() <= PN);
    for (int k = 0; k < idx.size() && k < PN; k++) begin
      b.mask[idx[k]] = 1'b1;
      b.port[idx[k]*IW +: IW] = IW'(k);
    end
    q.push_back(b);
    if (idx.size() > PN) begin
      b.mask = '0; b.port = '0; b.seq = 1'b1; b.last = 1'b1;
      for (int k = PN; k < idx.size() && k < 2 * PN; k++) begin
        b.mask[idx[k]] = 1'b1;
        b.port[idx[k]*IW +: IW] = IW'(k - PN);
      end
      q.push_back(b);
    end
  endtask

  // Monitor: mid-cycle, compare outputs with the model, then advance the
  // model by what will happen at the next rising edge.
  always @(negedge sys_clk) begin
    m_empty = (q.size() == 0);
    chk("rqst_ready", {31'd0, rqst_ready_o}, {31'd0, m_empty & pipe_begin_i});
    chk("busy", {31'd0, busy_o}, {31'd0, !m_empty});
    chk("alloc_valid", {31'd0, alloc_valid_o}, {31'd0, !m_empty});
    chk("isGtr", {31'd0, isGtr_o}, {31'd0, exp_gtr});
    chk("err_ovf", {31'd0, err_ovf_o}, {31'd0, m_err});
    if (!m_empty) begin
      chk("alloc_mask", {20'd0, alloc_mask_o}, {20'd0, q[0].mask});
      chk("alloc_port", {8'd0, alloc_port_o}, {8'd0, q[0].port});
      chk("alloc_seq", {31'd0, alloc_seq_o}, {31'd0, q[0].seq});
      chk("alloc_last", {31'd0, alloc_last_o}, {31'd0, q[0].last});
    end else begin
      chk("idle_mask", {20'd0, alloc_mask_o}, 32'd0);
      chk("idle_port", {8'd0, alloc_port_o}, 32'd0);
      chk("idle_seq_last", {30'd0, alloc_seq_o, alloc_last_o}, 32'd0);
    end
    exp_gtr = 1'b0;
    if (!rstn) begin
      q.delete();
      m_err = 1'b0;
    end else begin
      if (!m_empty && alloc_ready_i) void'(q.pop_front());
      if (m_empty && pipe_begin_i && rqst_valid_i) model_accept(rqst_mask_i);
    end
  end

  // Handshake-side input drivers, applied shortly after each rising edge.
  always @(posedge sys_clk) begin
    #2;
    alloc_ready_i = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
    pipe_begin_i  = pb_rand ? ($urandom_range(0, 2) != 0) : pb_force;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic wait_accept();
    logic acc;
    acc = 1'b0;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge sys_clk);
      acc = rqst_ready_o;
      @(posedge sys_clk);
      #1;
    end
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    rqst_valid_i = 1'b0;
  endtask

  task automatic req(input logic [RN-1:0] m);
    rqst_mask_i  = m;
    rqst_valid_i = 1'b1;
    wait_accept();
  endtask

  initial begin
    logic [RN-1:0] rm;
    int            drain;
    cyc(3);
    rstn = 1'b1;
    cyc(2);

    req(12'h005);
    cyc(3);
    req(12'h07F);
    cyc(4);

    // Acceptance gating
    pb_force = 1'b0;
    cyc(1);
    rqst_mask_i  = 12'h0A3;
    rqst_valid_i = 1'b1;
    cyc(3);
    pb_force = 1'b1;
    wait_accept();
    cyc(3);

    // Backpressure, with a second request pending while busy
    rdy_force = 1'b0;
    req(12'h07F);
    rqst_mask_i  = 12'h0F0;
    rqst_valid_i = 1'b1;
    cyc(3);
    rdy_force = 1'b1;
    wait_accept();
    cyc(4);

    // Overflow, then an empty mask
    req(12'h3FF);
    cyc(4);
    req(12'h000);
    cyc(3);

    // Reset while stalled in the second sequence
    rdy_force = 1'b0;
    req(12'h07F);
    rdy_force = 1'b1;
    cyc(1);
    rdy_force = 1'b0;
    cyc(2);
    pb_force = 1'b0;
    rstn = 1'b0;
    cyc(1);
    rstn = 1'b1;
    pb_force = 1'b1;
    rdy_force = 1'b1;
    cyc(2);
    req(12'h001);
    cyc(3);

    // Randomized traffic
    rdy_rand = 1'b1;
    pb_rand  = 1'b1;
    for (int n = 0; n < 250; n++) begin
      cyc($urandom_range(0, 2));
      case ($urandom_range(0, 4))
        0:       rm = RN'($urandom) & RN'($urandom) & RN'($urandom);
        1:       rm = RN'($urandom) & RN'($urandom);
        2:       rm = RN'($urandom);
        3:       rm = RN'($urandom) | RN'($urandom);
        default: rm = RN'(1) << $urandom_range(0, RN - 1);
      endcase
      if ($urandom_range(0, 19) == 0) rm = '0;
      req(rm);
    end

    rdy_rand = 1'b0;
    pb_rand  = 1'b0;
    rdy_force = 1'b1;
    drain = 0;
    while (q.size() != 0 && drain < 50) begin
      cyc(1);
      drain++;
    end
    chk("drain_empty", q.size(), 32'd0);
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1);
  end

endmodule
